burst_accumulator: RTL

Parametrised successor to the team's 5-bit combinational adder. Sums a burst of BURST_LEN unsigned samples arriving over a valid/ready input handshake, then presents the total on a valid/ready output handshake. Sits between a sample source and a downstream consumer in the accumulator datapath. Adds sequential behaviour the plain adder lacks: wider accumulator, overflow detection, backpressure and synchronous clear.

---
 rtl/burst_accumulator.sv | 95 +++++++++
 1 files changed

// File: rtl/burst_accumulator.sv
// Burst accumulator: sums BURST_LEN unsigned samples over a valid/ready input and
// presents the total on a valid/ready output. Optional ACC_SAT_EN saturates instead of wrapping.
module burst_accumulator #(
    parameter int WIDTH     = 5,
    parameter int ACC_WIDTH = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int              CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     count;
    logic                 ovf;

    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_next;
    logic                 accept;
    logic                 deliver;
    logic                 last;

    // The top bit of the widened sum is the carry out of the accumulator.
    assign sum_wide = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);
`ifdef ACC_SAT_EN
    assign acc_next = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
    assign acc_next = sum_wide[ACC_WIDTH-1:0];
`endif
    assign ovf_next  = ovf | sum_wide[ACC_WIDTH];

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign last      = (count == LAST_CNT);

    // Clear outranks both a same-cycle accept and a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACCUM;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (clear) begin
            state <= ST_ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            out_sum <= acc_next;
                            out_ovf <= ovf_next;
                            acc     <= '0;
                            count   <= '0;
                            ovf     <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            acc   <= acc_next;
                            count <= count + CNT_W'(1);
                            ovf   <= ovf_next;
                        end
                    end
                end
                ST_DONE: begin
                    if (deliver) begin
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule
